// File: rtl/cflog_pkg.sv
// Shared definitions for the CF-Log writer: FSM states, record marker and
// the bit layout of one buffered control-flow event.
package cflog_pkg;

    localparam int EVT_W   = 32;
    localparam int WORD_W  = 16;
    localparam int SRC_LSB = 16;
    localparam int DST_LSB = 0;

    localparam logic [WORD_W-1:0] MARK    = 16'hFFFF;
    localparam logic [WORD_W-1:0] REP_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_WR_SRC  = 3'd2,
        ST_WR_DST  = 3'd3,
        ST_WR_MARK = 3'd4,
        ST_WR_CNT  = 3'd5,
        ST_FLUSH   = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/cflog_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; a push while full
// is accepted only when a pop happens in the same cycle.
module cflog_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/cflog_writer.sv
// Serialises control-flow events into the CF-Log SRAM, folding runs of
// identical (src,dest) pairs into a MARK + repeat-count record.
module cflog_writer
    import cflog_pkg::*;
#(
    parameter logic [15:0] LOG_BASE   = 16'h0240,
    parameter int          LOG_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MARK_WORD  = cflog_pkg::MARK
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cflow_hw_wen,
    input  logic [15:0] cflow_src,
    input  logic [15:0] cflow_dest,
    input  logic        ER_done,
    input  logic        flush_ack,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] log_ptr,
    output logic        flush_req,
    output logic        done,
    output logic        ovf
);
    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic [15:0] last_src_q, last_src_d;
    logic [15:0] last_dst_q, last_dst_d;
    logic        last_valid_q, last_valid_d;
    logic        done_pend_q, done_pend_d;
    logic        drain_q, drain_d;
    logic        ovf_q, ovf_d;
    logic        mem_wen_q, mem_wen_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        flush_req_q, flush_req_d;
    logic        done_q, done_d;

    logic [EVT_W-1:0] head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [15:0]      head_src, head_dst, ptr_addr;
    logic             match, room_need, room_rep;

    cflog_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (cflow_hw_wen),
        .pop   (fifo_pop),
        .din   ({cflow_src, cflow_dest}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_src = head[SRC_LSB +: WORD_W];
    assign head_dst = head[DST_LSB +: WORD_W];
    assign ptr_addr = LOG_BASE + {ptr_q[14:0], 1'b0};
    assign match    = last_valid_q && (head_src == last_src_q) &&
                      (head_dst == last_dst_q) && (rep_cnt_q != REP_MAX);
    // A pending repeat record must fit alongside the new pair.
    assign room_need = ({1'b0, ptr_q} + ((rep_cnt_q != '0) ? 17'd4 : 17'd2)) <= 17'(LOG_WORDS);
    assign room_rep  = ({1'b0, ptr_q} + 17'd2) <= 17'(LOG_WORDS);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rep_cnt_d    = rep_cnt_q;
        last_src_d   = last_src_q;
        last_dst_d   = last_dst_q;
        last_valid_d = last_valid_q;
        drain_d      = drain_q;
        done_pend_d  = done_pend_q | ER_done;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_CHECK;
                end else if (done_pend_q) begin
                    if (rep_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else if (room_rep) begin
                        state_d = ST_WR_MARK;
                        drain_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_CHECK: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    fifo_pop  = 1'b1;
                    rep_cnt_d = rep_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end else if (!room_need) begin
                    state_d = ST_FLUSH;
                end else if (rep_cnt_q != '0) begin
                    state_d = ST_WR_MARK;
                    drain_d = 1'b0;
                end else begin
                    state_d = ST_WR_SRC;
                end
            end
            ST_WR_MARK: begin
                mem_wen_d   = 1'b1;
                mem_addr_d  = ptr_addr;
                mem_wdata_d = MARK_WORD;
                ptr_d       = ptr_q + 16'd1;
                state_d     = ST_WR_CNT;
            end
            ST_WR_CNT: begin
                mem_wen_d   = 1'b1;
                mem_addr_d  = ptr_addr;
                mem_wdata_d = rep_cnt_q;
                ptr_d       = ptr_q + 16'd1;
                rep_cnt_d   = '0;
                drain_d     = 1'b0;
                state_d     = drain_q ? ST_DONE : ST_WR_SRC;
            end
            ST_WR_SRC: begin
                mem_wen_d   = 1'b1;
                mem_addr_d  = ptr_addr;
                mem_wdata_d = head_src;
                ptr_d       = ptr_q + 16'd1;
                state_d     = ST_WR_DST;
            end
            ST_WR_DST: begin
                mem_wen_d    = 1'b1;
                mem_addr_d   = ptr_addr;
                mem_wdata_d  = head_dst;
                ptr_d        = ptr_q + 16'd1;
                fifo_pop     = 1'b1;
                last_src_d   = head_src;
                last_dst_d   = head_dst;
                last_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    ptr_d        = '0;
                    last_valid_d = 1'b0;
                    state_d      = ST_CHECK;
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                done_pend_d  = ER_done;
                last_valid_d = 1'b0;
                rep_cnt_d    = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ovf_d       = ovf_q | (cflow_hw_wen & fifo_full & ~fifo_pop);
        flush_req_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rep_cnt_q    <= '0;
            last_src_q   <= '0;
            last_dst_q   <= '0;
            last_valid_q <= 1'b0;
            done_pend_q  <= 1'b0;
            drain_q      <= 1'b0;
            ovf_q        <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flush_req_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rep_cnt_q    <= rep_cnt_d;
            last_src_q   <= last_src_d;
            last_dst_q   <= last_dst_d;
            last_valid_q <= last_valid_d;
            done_pend_q  <= done_pend_d;
            drain_q      <= drain_d;
            ovf_q        <= ovf_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            flush_req_q  <= flush_req_d;
            done_q       <= done_d;
        end
    end

    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign log_ptr   = ptr_q;
    assign flush_req = flush_req_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer with an 8-word log so flushes are reachable.
module tb_cflog_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cflow_hw_wen = 1'b0;
    logic [15:0] cflow_src = '0;
    logic [15:0] cflow_dest = '0;
    logic        ER_done = 1'b0;
    logic        flush_ack = 1'b0;
    logic        mem_wen;
    logic [15:0] mem_addr, mem_wdata, log_ptr;
    logic        flush_req, done, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_addr [256];
    logic [15:0] wr_data [256];
    int          wcnt     = 0;
    int          done_cnt = 0;

    cflog_writer #(
        .LOG_BASE   (16'h0240),
        .LOG_WORDS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cflow_hw_wen (cflow_hw_wen),
        .cflow_src    (cflow_src),
        .cflow_dest   (cflow_dest),
        .ER_done      (ER_done),
        .flush_ack    (flush_ack),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .log_ptr      (log_ptr),
        .flush_req    (flush_req),
        .done         (done),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    // Capture every SRAM write and every done cycle.
    always @(negedge clk) begin
        if (mem_wen === 1'b1 && wcnt < 256) begin
            wr_addr[wcnt] = mem_addr;
            wr_data[wcnt] = mem_wdata;
            wcnt = wcnt + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cflow_hw_wen = 1'b0;
        ER_done = 1'b0;
        flush_ack = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    // Caller is positioned just after a falling edge.
    task automatic pulse_evt(input logic [15:0] s, input logic [15:0] d);
        cflow_hw_wen = 1'b1;
        cflow_src = s;
        cflow_dest = d;
        @(negedge clk);
        cflow_hw_wen = 1'b0;
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] d);
        pulse_evt(s, d);
        idle(8);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wen: got %b want 0", mem_wen); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
        n_checks++; if (log_ptr !== 16'h0) begin n_fail++; $display("FAIL reset_log_ptr: got %0d want 0", log_ptr); end
        n_checks++; if ({flush_req, done, ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {flush_req, done, ovf}); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [6];
        int base;
        exp_d = '{16'hE000, 16'hE010, 16'hE012, 16'hE100, 16'hE104, 16'hE020};
        do_reset();
        base = wcnt;
        pulse_evt(16'hE000, 16'hE010);
        idle(2);
        n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL lat_early: got mem_wen=%b want 0 at t+2", mem_wen); end
        idle(1);
        n_checks++; if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 16'h0240, 16'hE000}) begin n_fail++; $display("FAIL lat_src: got wen=%b addr=%h data=%h want 1/0240/E000", mem_wen, mem_addr, mem_wdata); end
        idle(1);
        n_checks++; if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 16'h0242, 16'hE010}) begin n_fail++; $display("FAIL lat_dst: got wen=%b addr=%h data=%h want 1/0242/E010", mem_wen, mem_addr, mem_wdata); end
        idle(6);
        send(16'hE012, 16'hE100);
        send(16'hE104, 16'hE020);
        n_checks++; if (wcnt - base !== 6) begin n_fail++; $display("FAIL basic_count: got %0d want 6", wcnt - base); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (wr_data[base+i] !== exp_d[i] || wr_addr[base+i] !== 16'h0240 + 16'(2*i)) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h@%h want %h@%h", i, wr_data[base+i], wr_addr[base+i], exp_d[i], 16'h0240 + 16'(2*i));
            end
        end
        n_checks++; if (log_ptr !== 16'd6) begin n_fail++; $display("FAIL basic_ptr: got %0d want 6", log_ptr); end
    endtask

    task automatic test_compress();
        logic [15:0] exp_d [6];
        int base;
        exp_d = '{16'hE010, 16'hE000, 16'hFFFF, 16'h0004, 16'hE100, 16'hE200};
        do_reset();
        base = wcnt;
        for (int k = 0; k < 5; k++) send(16'hE010, 16'hE000);
        send(16'hE100, 16'hE200);
        n_checks++; if (wcnt - base !== 6) begin n_fail++; $display("FAIL comp_count: got %0d want 6", wcnt - base); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (wr_data[base+i] !== exp_d[i] || wr_addr[base+i] !== 16'h0240 + 16'(2*i)) begin
                n_fail++;
                $display("FAIL comp_word%0d: got %h@%h want %h@%h", i, wr_data[base+i], wr_addr[base+i], exp_d[i], 16'h0240 + 16'(2*i));
            end
        end
        n_checks++; if (log_ptr !== 16'd6) begin n_fail++; $display("FAIL comp_ptr: got %0d want 6", log_ptr); end
    endtask

    task automatic test_flush_ovf();
        logic [15:0] exp_d [8];
        int base;
        int waited;
        exp_d = '{16'hA400, 16'hA402, 16'hB000, 16'hB002, 16'hB100, 16'hB102, 16'hB200, 16'hB202};
        do_reset();
        base = wcnt;
        for (int k = 0; k < 4; k++) send(16'hA000 + 16'(k * 16'h100), 16'hA002 + 16'(k * 16'h100));
        pulse_evt(16'hA400, 16'hA402);
        waited = 0;
        while (flush_req !== 1'b1 && waited < 20) begin
            idle(1);
            waited++;
        end
        n_checks++; if (flush_req !== 1'b1) begin n_fail++; $display("FAIL flush_raise: got flush_req=%b want 1 within 20 cycles", flush_req); end
        idle(3);
        n_checks++; if (log_ptr !== 16'd8) begin n_fail++; $display("FAIL flush_ptr: got %0d want 8", log_ptr); end
        n_checks++; if (wcnt - base !== 8 || flush_req !== 1'b1) begin n_fail++; $display("FAIL flush_hold: got writes=%0d req=%b want 8/1", wcnt - base, flush_req); end
        pulse_evt(16'hB000, 16'hB002);
        pulse_evt(16'hB100, 16'hB102);
        pulse_evt(16'hB200, 16'hB202);
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0 with 4 queued", ovf); end
        pulse_evt(16'hB300, 16'hB302);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1 after 5th event", ovf); end
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
        idle(30);
        n_checks++; if (wcnt - base !== 16) begin n_fail++; $display("FAIL post_flush_count: got %0d want 16", wcnt - base); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wr_data[base+8+i] !== exp_d[i] || wr_addr[base+8+i] !== 16'h0240 + 16'(2*i)) begin
                n_fail++;
                $display("FAIL post_flush_word%0d: got %h@%h want %h@%h", i, wr_data[base+8+i], wr_addr[base+8+i], exp_d[i], 16'h0240 + 16'(2*i));
            end
        end
        n_checks++; if ({log_ptr, flush_req, ovf} !== {16'd8, 1'b0, 1'b1}) begin n_fail++; $display("FAIL post_flush_state: got ptr=%0d req=%b ovf=%b want 8/0/1", log_ptr, flush_req, ovf); end
    endtask

    task automatic test_done();
        logic [15:0] exp_d [4];
        int base;
        int dc0;
        exp_d = '{16'hE010, 16'hE000, 16'hFFFF, 16'h0001};
        do_reset();
        base = wcnt;
        dc0 = done_cnt;
        send(16'hE010, 16'hE000);
        send(16'hE010, 16'hE000);
        n_checks++; if (done_cnt - dc0 !== 0) begin n_fail++; $display("FAIL done_early: got %0d pulses want 0", done_cnt - dc0); end
        ER_done = 1'b1;
        @(negedge clk);
        ER_done = 1'b0;
        idle(10);
        n_checks++; if (wcnt - base !== 4) begin n_fail++; $display("FAIL done_count: got %0d want 4", wcnt - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_data[base+i] !== exp_d[i] || wr_addr[base+i] !== 16'h0240 + 16'(2*i)) begin
                n_fail++;
                $display("FAIL done_word%0d: got %h@%h want %h@%h", i, wr_data[base+i], wr_addr[base+i], exp_d[i], 16'h0240 + 16'(2*i));
            end
        end
        n_checks++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL done_pulse: got %0d cycles want 1", done_cnt - dc0); end
        n_checks++; if (log_ptr !== 16'd4) begin n_fail++; $display("FAIL done_ptr: got %0d want 4", log_ptr); end
        ER_done = 1'b1;
        @(negedge clk);
        ER_done = 1'b0;
        idle(8);
        n_checks++; if (wcnt - base !== 4 || done_cnt - dc0 !== 2) begin n_fail++; $display("FAIL done_empty: got writes=%0d pulses=%0d want 4/2", wcnt - base, done_cnt - dc0); end
    endtask

    task automatic test_reset_mid();
        int snap;
        do_reset();
        pulse_evt(16'hE104, 16'hE020);
        idle(3);
        n_checks++; if (mem_wen !== 1'b1) begin n_fail++; $display("FAIL mid_precond: got mem_wen=%b want 1", mem_wen); end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({mem_wen, mem_addr, mem_wdata, log_ptr} !== 49'h0) begin n_fail++; $display("FAIL mid_outputs: got wen=%b addr=%h data=%h ptr=%0d want all 0", mem_wen, mem_addr, mem_wdata, log_ptr); end
        n_checks++; if ({flush_req, done, ovf} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b want 000", {flush_req, done, ovf}); end
        reset_n = 1'b1;
        idle(1);
        snap = wcnt;
        idle(10);
        n_checks++; if (wcnt !== snap || log_ptr !== 16'd0) begin n_fail++; $display("FAIL mid_fifo_empty: got writes=%0d ptr=%0d want 0/0", wcnt - snap, log_ptr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compress();
        test_flush_ovf();
        test_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
